// File: rtl/mvau_defn.sv
// rtl/mvau_defn.sv - shared types and fold constants for the MVAU stream controller
package mvau_defn;

    typedef enum logic {
        WRITE = 1'b0,   // first neuron fold: activations come from the stream
        READ  = 1'b1    // later neuron folds: activations replayed from the buffer
    } state_t;

    // Reference layer geometry; SF/NF defaults of the controller derive from it.
    localparam int MATRIX_W   = 16;
    localparam int MATRIX_H   = 8;
    localparam int SIMD       = 4;
    localparam int PE         = 4;
    localparam int SF_DEF     = MATRIX_W / SIMD;
    localparam int NF_DEF     = MATRIX_H / PE;
    localparam int WMEM_DEPTH = SF_DEF * NF_DEF;

    // Counter/address width for a range of n values, never narrower than 1 bit.
    function automatic int addr_bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvau_stream_ctrl_if.sv
// rtl/mvau_stream_ctrl_if.sv - handshake and memory-control bundle of the MVAU sequencer
// master: the sequencer (drives in_rdy, buffer/weight controls, compute strobes)
// slave : the surrounding stream source, buffers, weight memories and datapath
interface mvau_stream_ctrl_if #(
    parameter int IBUF_ADDR_BW = 2,
    parameter int WMEM_ADDR_BW = 3
);
    logic                    in_v;
    logic                    in_rdy;
    logic                    out_rdy;
    logic                    ibuf_we;
    logic [IBUF_ADDR_BW-1:0] ibuf_waddr;
    logic                    ibuf_re;
    logic [IBUF_ADDR_BW-1:0] ibuf_raddr;
    logic                    wmem_en;
    logic [WMEM_ADDR_BW-1:0] wmem_addr;
    logic                    sel_buf;
    logic                    comp_v;
    logic                    acc_clr;
    logic                    acc_last;

    modport master (
        input  in_v, out_rdy,
        output in_rdy, ibuf_we, ibuf_waddr, ibuf_re, ibuf_raddr,
               wmem_en, wmem_addr, sel_buf, comp_v, acc_clr, acc_last
    );

    modport slave (
        output in_v, out_rdy,
        input  in_rdy, ibuf_we, ibuf_waddr, ibuf_re, ibuf_raddr,
               wmem_en, wmem_addr, sel_buf, comp_v, acc_clr, acc_last
    );
endinterface

// File: rtl/mvau_wrap_counter.sv
// rtl/mvau_wrap_counter.sv - enable-stepped counter over 0..MAX-1 with wrap flag
// en   : advance by one (wrapping to 0 after MAX-1)
// cnt  : current count
// wrap : count is at MAX-1, so the next enabled step returns to 0
module mvau_wrap_counter #(
    parameter int MAX = 4,
    parameter int BW  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [BW-1:0] cnt,
    output logic          wrap
);
    localparam logic [BW-1:0] LAST = BW'(MAX - 1);

    assign wrap = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mvau_stream_ctrl.sv
// rtl/mvau_stream_ctrl.sv - stall-aware fold sequencer for the MVAU compute pipeline
// clk, rst_n : clock, asynchronous active-low reset
// bus.in_v/in_rdy    : activation stream handshake (accepted only on the first neuron fold)
// bus.out_rdy        : datapath can take a compute beat
// bus.ibuf_*         : input buffer write (first fold) / read (later folds) at the SF index
// bus.wmem_en/addr   : weight memory read, address steps once per beat
// bus.comp_v/acc_*/sel_buf : registered strobes aligned with synchronous-read data
module mvau_stream_ctrl
    import mvau_defn::*;
#(
    parameter int SF           = SF_DEF,
    parameter int NF           = NF_DEF,
    parameter int WMEM_ADDR_BW = addr_bw(SF * NF),
    parameter int IBUF_ADDR_BW = addr_bw(SF)
) (
    input  logic clk,
    input  logic rst_n,
    mvau_stream_ctrl_if.master bus
);
    localparam int NF_BW = addr_bw(NF);

    state_t                  state;
    logic                    step;
    logic [IBUF_ADDR_BW-1:0] sf_cnt;
    logic                    sf_wrap;
    logic [NF_BW-1:0]        nf_cnt;
    logic                    nf_wrap;
    logic [WMEM_ADDR_BW-1:0] wmem_cnt;
    logic                    wmem_wrap;
    logic                    comp_v_q, acc_clr_q, acc_last_q, sel_buf_q;

    // Stream is only consumed while writing; replay folds depend on out_rdy alone.
    assign step       = (state == WRITE) ? (bus.in_v & bus.out_rdy) : bus.out_rdy;
    assign bus.in_rdy = (state == WRITE) & bus.out_rdy;

    mvau_wrap_counter #(.MAX(SF), .BW(IBUF_ADDR_BW)) u_sf_cnt (
        .clk(clk), .rst_n(rst_n), .en(step), .cnt(sf_cnt), .wrap(sf_wrap)
    );

    mvau_wrap_counter #(.MAX(NF), .BW(NF_BW)) u_nf_cnt (
        .clk(clk), .rst_n(rst_n), .en(step & sf_wrap), .cnt(nf_cnt), .wrap(nf_wrap)
    );

    mvau_wrap_counter #(.MAX(SF * NF), .BW(WMEM_ADDR_BW)) u_wmem_cnt (
        .clk(clk), .rst_n(rst_n), .en(step), .cnt(wmem_cnt), .wrap(wmem_wrap)
    );

    assign bus.ibuf_we    = step & (state == WRITE);
    assign bus.ibuf_waddr = sf_cnt;
    assign bus.ibuf_re    = step & (state == READ);
    assign bus.ibuf_raddr = sf_cnt;
    assign bus.wmem_en    = step;
    assign bus.wmem_addr  = wmem_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WRITE;
            comp_v_q   <= 1'b0;
            acc_clr_q  <= 1'b0;
            acc_last_q <= 1'b0;
            sel_buf_q  <= 1'b0;
        end else begin
            if (step && sf_wrap) begin
                if (nf_wrap) begin
                    state <= WRITE;
                end else if (nf_cnt == '0) begin
                    state <= READ;
                end
            end
            // One-cycle delay matches the synchronous read of buffer and weights.
            comp_v_q   <= step;
            acc_clr_q  <= step & (sf_cnt == '0);
            acc_last_q <= step & sf_wrap;
            sel_buf_q  <= (state == READ);
        end
    end

    // The weight address wraps exactly at the end of the last neuron fold.
    always_ff @(posedge clk) begin
        if (rst_n && step) begin
            assert (wmem_wrap == (sf_wrap && nf_wrap));
        end
    end

    assign bus.comp_v   = comp_v_q;
    assign bus.acc_clr  = acc_clr_q;
    assign bus.acc_last = acc_last_q;
    assign bus.sel_buf  = sel_buf_q;
endmodule

// File: doc/mvau_stream_ctrl.md
# mvau_stream_ctrl

Stall-aware sequencer for the MVAU compute pipeline. It replaces a free-running weight-address counter with handshake-driven scheduling: it accepts the input activation stream, writes it into the input buffer on the first neuron fold, and replays it from the buffer on later folds. It steps the weight-memory address in lockstep with the fold counters and issues aligned compute-valid and accumulator-control strobes. It sits between the input stream, the input buffer, the weight memories and the PE/SIMD datapath.

## Interface
- SF, default 4: synapse folds per vector (MatrixW/SIMD), ≥1
- NF, default 2: neuron folds (MatrixH/PE), ≥1
- WMEM_ADDR_BW, default $clog2(SF*NF) (min 1): weight address width
- IBUF_ADDR_BW, default $clog2(SF) (min 1): input buffer address width

Ports:
- clk  in  1  main clock
- rst_n  in  1  reset, asynchronous, active-low
- in_v  in  1  input activation word valid
- in_rdy  out  1  input activation word accepted when in_v&in_rdy
- out_rdy  in  1  datapath/output can accept a new compute beat
- ibuf_we  out  1  input buffer write enable
- ibuf_waddr  out  IBUF_ADDR_BW  input buffer write address
- ibuf_re  out  1  input buffer read enable
- ibuf_raddr  out  IBUF_ADDR_BW  input buffer read address
- wmem_en  out  1  weight memory read enable
- wmem_addr  out  WMEM_ADDR_BW  weight memory address
- sel_buf  out  1  datapath takes activation from buffer (1) or stream (0); registered, aligned with comp_v
- comp_v  out  1  compute beat valid at datapath
- acc_clr  out  1  first SF beat of a neuron fold (load, not accumulate)
- acc_last  out  1  last SF beat; accumulator result is final

## Operation
- State register has two states:
  - WRITE (nf_cnt==0): activations come from the stream.
  - READ (nf_cnt>0): activations come from the buffer.
- Counters:
  - sf_cnt wraps at SF.
  - nf_cnt wraps at NF.
  - wmem_cnt counts 0..SF*NF-1 and wraps to 0.
- step:
  - In WRITE: step = in_v & out_rdy. in_rdy = out_rdy (combinational).
  - In READ: step = out_rdy. in_rdy = 0.
- On step:
  - sf_cnt++.
  - On sf_cnt==SF-1: sf_cnt←0 and nf_cnt++.
  - On nf_cnt==NF-1 with sf_cnt==SF-1: nf_cnt←0 and state←WRITE.
  - wmem_cnt++ with wrap.
  - State←READ when leaving nf_cnt==0 and NF>1.
- Combinational outputs:
  - ibuf_we = step & WRITE. ibuf_waddr = sf_cnt.
  - ibuf_re = step & READ. ibuf_raddr = sf_cnt.
  - wmem_en = step. wmem_addr = wmem_cnt.
- Registered outputs, updated every cycle:
  - comp_v ← step.
  - acc_clr ← step & (sf_cnt==0).
  - acc_last ← step & (sf_cnt==SF-1).
  - sel_buf ← READ.
- No step means counters hold and comp_v is 0 next cycle.
- SF=1: acc_clr and acc_last both 1 on every beat.
- NF=1: the block never leaves WRITE; the buffer is written but never read.

## Timing
- Reset (async assert, sync-safe deassert): all counters 0, state WRITE, comp_v/acc_clr/acc_last/sel_buf 0.
  - Combinational outputs follow: wmem_addr 0, ibuf addresses 0, enables 0 unless a step occurs.
- Latency is 1 cycle from step (address issue) to comp_v, matching synchronous-read memories.
- Full throughput is one beat per cycle while in_v (WRITE) and out_rdy stay high.
- Simultaneous wrap of sf, nf and wmem on one step: all three reach 0 together and the next beat is WRITE with acc_clr.
- out_rdy low in READ freezes raddr and wmem_addr. The stall may last any number of cycles with no loss.
- in_v high with out_rdy low: no accept, no write.
- Reset asserted mid-vector discards the partial vector. The first post-reset beat uses wmem_addr 0.

## Structure
- Shared package mvau_defn:
  - state typedef enum {WRITE, READ}.
  - SF/NF derivation constants from MatrixW, MatrixH, SIMD, PE.
  - A WMEM_DEPTH=SF*NF constant.
- One natural sub-module, mvau_wrap_counter (parameters MAX, BW; ports en, cnt, wrap). Instantiate it for sf, nf and wmem.

## Test plan
- SF=4, NF=2, in_v and out_rdy held high:
  - wmem_addr 0..7 then 0, one per cycle.
  - ibuf_we for beats 0–3 at waddr 0..3; ibuf_re for beats 4–7 at raddr 0..3.
  - in_rdy low during beats 4–7.
  - acc_clr on beats 0 and 4, acc_last on beats 3 and 7, comp_v 1 cycle after each beat.
- out_rdy low for 3 cycles at READ beat raddr=2:
  - raddr and wmem_addr hold at 2/6.
  - comp_v is 0 for those 3 cycles and resumes at 6.
  - No beat is duplicated or skipped.
- in_v toggled 1,0,1,0 in WRITE: only accepted beats advance waddr 0,1,2,3, and the comp_v pattern matches the acceptances.
- SF=1, NF=1: every accepted beat has acc_clr=acc_last=1, and wmem_addr stays 0.
- rst_n pulsed low asynchronously at READ beat wmem_addr=5:
  - Outputs clear immediately (comp_v 0).
  - After release the next beat is WRITE, wmem_addr 0, acc_clr 1.
- 10 back-to-back vectors at SF=3, NF=3: wmem_addr sequence repeats 0..8, and there is no wrap off-by-one on the last beat.
